// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: load handshake and serial line bundle for serial_frame_tx.
// master = word producer / line observer, slave = the transmitter.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             tx;
    logic             busy;
    logic             done;

    modport master (
        output data_in, load_valid,
        input  load_ready, tx, busy, done
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, tx, busy, done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-in / serial-out frame transmitter, LSB first.
// Frame: start(0), WIDTH data bits, optional even parity bit, stop(1).
// Each bit is held on tx for BIT_CYCLES clocks; the line idles high.
// Optional feature macro: PARITY_EN (adds the PARITY state and parity logic).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line high, load_ready=1, waiting for load_valid
// S_START | start bit (tx=0)
// S_DATA  | data bit r_idx, driven from r_shift[0]
// S_PARITY| even parity of the latched word (PARITY_EN only)
// S_STOP  | stop bit (tx=1), done in its final cycle
module serial_frame_tx #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_frame_tx_if.slave   bus
);

    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic               r_tx;
    logic               w_tx_next;
    logic               w_bit_end;
    logic               w_accept;
`ifdef PARITY_EN
    logic               r_parity;
`endif

    assign w_bit_end = (r_cnt == '0);
    assign w_accept  = (r_state == S_IDLE) && bus.load_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: each bit state advances when its down-counter reaches zero
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.load_valid) w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_idx == IDX_LAST)) begin
`ifdef PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                if (w_bit_end) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_end) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: handshake and status depend on state only
    always_comb begin
        bus.load_ready = (r_state == S_IDLE);
        bus.busy       = (r_state != S_IDLE);
        bus.done       = (r_state == S_STOP) && w_bit_end;
        bus.tx         = r_tx;
    end

    // Next shift-register contents and the line value for the next cycle;
    // tx is computed from the next state so the line changes on the same
    // edge as the state (start bit appears on the accept edge).
    always_comb begin
        w_shift_next = r_shift;
        if (w_accept) begin
            w_shift_next = bus.data_in;
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_next = r_shift >> 1;
        end

        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Bit timer, bit index, shift register and registered line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            if ((w_state_next != r_state) || ((r_state == S_DATA) && w_bit_end)) begin
                r_cnt <= CNT_LOAD;
            end else if (!w_bit_end) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if ((w_state_next == S_DATA) && (r_state != S_DATA)) begin
                r_idx <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_idx <= r_idx + 1'b1;
            end

            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

`ifdef PARITY_EN
    // Parity is fixed at accept so later data_in changes cannot affect it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^bus.data_in;
        end
    end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed + random frames on two transmitters
// (BIT_CYCLES=4 and BIT_CYCLES=1), compared against a frame-bit model.
module tb_serial_frame_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.WIDTH(8)) if0 ();
    serial_frame_tx_if #(.WIDTH(8)) if1 ();

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 8 + 2 + PAR;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {tx, busy, done, load_ready}
    function automatic logic [3:0] obs(input int s);
        if (s == 0) return {if0.tx, if0.busy, if0.done, if0.load_ready};
        else        return {if1.tx, if1.busy, if1.done, if1.load_ready};
    endfunction

    task automatic drive(input int s, input logic [7:0] d, input logic v);
        if (s == 0) begin
            if0.data_in = d; if0.load_valid = v;
        end else begin
            if1.data_in = d; if1.load_valid = v;
        end
    endtask

    // Model: value of frame bit b for word w
    function automatic logic frame_bit(input logic [7:0] w, input int b);
        if (b == 0)                return 1'b0;
        if (b <= 8)                return w[b-1];
        if ((PAR == 1) && (b == 9)) return ^w;
        return 1'b1;
    endfunction

    // Called at a negedge with the DUT idle. Checks every cycle of the frame
    // plus the first idle cycle after it. hold keeps load_valid high with
    // w_next on data_in for a back-to-back frame; scramble toggles data_in.
    task automatic send(input int s, input int bc, input logic [7:0] w,
                        input bit hold, input logic [7:0] w_next, input bit scramble);
        logic [3:0] o;
        logic       etx;
        int         len;
        len = NBITS * bc;
        o = obs(s);
        chk($sformatf("ready_before_%0d_%02h", s, w), {31'd0, o[0]}, 32'd1);
        drive(s, w, 1'b1);
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (hold) drive(s, w_next, 1'b1);
            else if (k == 0 || scramble) drive(s, 8'($urandom), (k == 0) ? 1'b0 : 1'b1 & scramble & ($urandom_range(0, 1) == 1));
            #1;
            o   = obs(s);
            etx = frame_bit(w, k / bc);
            chk($sformatf("frame_%0d_%02h_k%0d", s, w, k), {28'd0, o},
                {28'd0, etx, 1'b1, (k == len - 1), 1'b0});
        end
        @(negedge clk);
        #1;
        o = obs(s);
        chk($sformatf("idle_after_%0d_%02h", s, w), {28'd0, o}, {28'd0, 4'b1001});
    endtask

    initial begin
        logic [3:0] o;
        logic [7:0] w, w2;

        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);

        // Test 1: reset held 3 cycles, then 10 idle cycles
        repeat (3) @(posedge clk);
        #1;
        chk("in_reset0", {28'd0, obs(0)}, 32'h9);
        chk("in_reset1", {28'd0, obs(1)}, 32'h9);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle0_%0d", i), {28'd0, obs(0)}, 32'h9);
            chk($sformatf("idle1_%0d", i), {28'd0, obs(1)}, 32'h9);
        end

        // Tests 2/3: fixed words
        send(0, 4, 8'hA5, 1'b0, 8'h00, 1'b1);
        send(0, 4, 8'h07, 1'b0, 8'h00, 1'b1);

        // Test 4: load_valid held across two frames, then data_in toggling mid-frame
        send(0, 4, 8'h3C, 1'b1, 8'hC3, 1'b0);
        send(0, 4, 8'hC3, 1'b0, 8'h00, 1'b1);

        // Random words
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            send(0, 4, w, 1'b0, 8'h00, 1'b1);
        end

        // Test 5: async reset during data bit 3 of 0xFF
        drive(0, 8'hFF, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(0, 8'($urandom), 1'b0);
            #1;
            chk($sformatf("pre_abort_k%0d", k), {28'd0, obs(0)},
                {28'd0, frame_bit(8'hFF, k / 4), 3'b100});
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async", {28'd0, obs(0)}, 32'h9);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("abort_hold_%0d", i), {28'd0, obs(0)}, 32'h9);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_abort_idle", {28'd0, obs(0)}, 32'h9);
        send(0, 4, 8'h01, 1'b0, 8'h00, 1'b0);

        // Test 6: BIT_CYCLES=1 instance
        send(1, 1, 8'h80, 1'b0, 8'h00, 1'b1);
        w  = 8'($urandom);
        w2 = 8'($urandom);
        send(1, 1, w, 1'b1, w2, 1'b0);
        send(1, 1, w2, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            send(1, 1, w, 1'b0, 8'h00, 1'b1);
        end

        // The idle instance must have stayed idle throughout
        o = obs(0);
        chk("dut0_final_idle", {28'd0, o}, 32'h9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
